// File: rtl/nn_topology_sequencer_pkg.sv
// Shared definitions for the network-topology sequencer: bus widths, program format and state encoding.
package nn_topology_sequencer_pkg;

  localparam int NN_DATA_W = 8;
  localparam int NN_ADDR_W = 8;

  localparam logic [NN_ADDR_W-1:0] HDR_ADDR = '0;
  localparam logic [NN_DATA_W-1:0] END_WORD = '0;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH_IN    = 3'd1,
    S_FETCH_LAYER = 3'd2,
    S_ISSUE       = 3'd3,
    S_WAIT_DONE   = 3'd4,
    S_FINISH      = 3'd5
  } state_t;

endpackage

// File: rtl/nn_topology_sequencer_if.sv
// Instruction-RAM read bus plus layer-descriptor handshake between the sequencer and the layer datapath.
interface nn_topology_sequencer_if
  import nn_topology_sequencer_pkg::*;
#(
  parameter int LIDX_W = 3
) ();

  logic                 ram_en;
  logic [NN_ADDR_W-1:0] ram_addr;
  logic [NN_DATA_W-1:0] ram_data;

  logic                 layer_valid;
  logic                 layer_ready;
  logic [LIDX_W-1:0]    layer_idx;
  logic [NN_DATA_W-1:0] layer_in_count;
  logic [NN_DATA_W-1:0] layer_out_count;
  logic                 layer_done;

  modport master (
    output ram_en, ram_addr,
    input  ram_data,
    output layer_valid, layer_idx, layer_in_count, layer_out_count,
    input  layer_ready, layer_done
  );

  modport slave (
    input  ram_en, ram_addr,
    output ram_data,
    input  layer_valid, layer_idx, layer_in_count, layer_out_count,
    output layer_ready, layer_done
  );

endinterface

// File: rtl/nn_topology_sequencer.sv
// Walks the topology program in instruction RAM and hands one layer descriptor at a time to the datapath.
module nn_topology_sequencer
  import nn_topology_sequencer_pkg::*;
#(
  parameter int PROG_LEN   = 4,
  parameter int MAX_LAYERS = 8,
  parameter int LIDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  nn_topology_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LIDX_W:0]      num_layers
);

  localparam logic [NN_ADDR_W-1:0] END_ADDR = NN_ADDR_W'(PROG_LEN);
  localparam logic [LIDX_W:0]      MAX_N    = (LIDX_W+1)'(MAX_LAYERS);

  state_t               state, state_nx;
  logic [NN_ADDR_W-1:0] ram_addr;
  logic [LIDX_W-1:0]    layer_idx;
  logic [NN_DATA_W-1:0] in_count;
  logic [NN_DATA_W-1:0] out_count;
  logic                 at_end;
  logic                 end_word;
  logic                 list_full;

  // at_end gates the RAM enable, so data is never looked at past the program window
  assign at_end    = (ram_addr == END_ADDR);
  assign end_word  = (bus.ram_data == END_WORD);
  assign list_full = (num_layers == MAX_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:        if (start) state_nx = S_FETCH_IN;
      S_FETCH_IN:    state_nx = end_word ? S_FINISH : S_FETCH_LAYER;
      S_FETCH_LAYER: state_nx = (at_end || end_word || list_full) ? S_FINISH : S_ISSUE;
      S_ISSUE:       if (bus.layer_ready) state_nx = S_WAIT_DONE;
      S_WAIT_DONE:   if (bus.layer_done) state_nx = S_FETCH_LAYER;
      S_FINISH:      state_nx = S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      layer_idx  <= '0;
      in_count   <= '0;
      out_count  <= '0;
      num_layers <= '0;
      error      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            error      <= 1'b0;
            num_layers <= '0;
            ram_addr   <= HDR_ADDR;
            layer_idx  <= '0;
          end
        end
        S_FETCH_IN: begin
          in_count <= bus.ram_data;
          if (end_word) error    <= 1'b1;
          else          ram_addr <= HDR_ADDR + 1'b1;
        end
        S_FETCH_LAYER: begin
          if (!at_end && !end_word) begin
            if (list_full) error     <= 1'b1;
            else           out_count <= bus.ram_data;
          end
        end
        S_ISSUE: begin
          if (bus.layer_ready) num_layers <= num_layers + 1'b1;
        end
        S_WAIT_DONE: begin
          // the layer just finished feeds the next one
          if (bus.layer_done) begin
            in_count  <= out_count;
            layer_idx <= layer_idx + 1'b1;
            ram_addr  <= ram_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_en          = (state == S_FETCH_IN) || ((state == S_FETCH_LAYER) && !at_end);
  assign bus.ram_addr        = ram_addr;
  assign bus.layer_valid     = (state == S_ISSUE);
  assign bus.layer_idx       = layer_idx;
  assign bus.layer_in_count  = in_count;
  assign bus.layer_out_count = out_count;
  assign busy                = (state != S_IDLE);
  assign done                = (state == S_FINISH);

endmodule

// File: tb/tb_nn_topology_sequencer.sv
// Bench for nn_topology_sequencer: a short-program instance and a longer one share one RAM image and stimulus.
module tb_nn_topology_sequencer;

  localparam int MAX_LAYERS = 8;
  localparam int PLEN_A     = 4;
  localparam int PLEN_B     = 12;

  typedef struct { int idx; int inc; int outc; } desc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic ready = 1'b0;
  logic ldone = 1'b0;
  logic start_a, start_b;

  logic [7:0] mem [0:255];

  int vectors = 0;
  int miscompares = 0;

  desc_t exp_q[$];
  int    exp_err, exp_n, exp_last;

  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [3:0] nl_a, nl_b;

  logic       o_en, o_valid, o_busy, o_done, o_err;
  logic [7:0] o_addr, o_in, o_out;
  logic [2:0] o_idx;
  logic [3:0] o_nl;

  always #5 clk = ~clk;

  nn_topology_sequencer_if #(.LIDX_W(3)) ifa ();
  nn_topology_sequencer_if #(.LIDX_W(3)) ifb ();

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  // The floating RAM bus is modelled as a non-zero poison value so an unenabled read looks like a layer word.
  assign ifa.ram_data    = ifa.ram_en ? mem[ifa.ram_addr] : 8'hA5;
  assign ifb.ram_data    = ifb.ram_en ? mem[ifb.ram_addr] : 8'hA5;
  assign ifa.layer_ready = ready;
  assign ifb.layer_ready = ready;
  assign ifa.layer_done  = ldone;
  assign ifb.layer_done  = ldone;

  nn_topology_sequencer #(.PROG_LEN(PLEN_A), .MAX_LAYERS(MAX_LAYERS), .LIDX_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa.master),
    .busy(busy_a), .done(done_a), .error(err_a), .num_layers(nl_a)
  );

  nn_topology_sequencer #(.PROG_LEN(PLEN_B), .MAX_LAYERS(MAX_LAYERS), .LIDX_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb.master),
    .busy(busy_b), .done(done_b), .error(err_b), .num_layers(nl_b)
  );

  assign o_en    = sel ? ifb.ram_en          : ifa.ram_en;
  assign o_addr  = sel ? ifb.ram_addr        : ifa.ram_addr;
  assign o_valid = sel ? ifb.layer_valid     : ifa.layer_valid;
  assign o_idx   = sel ? ifb.layer_idx       : ifa.layer_idx;
  assign o_in    = sel ? ifb.layer_in_count  : ifa.layer_in_count;
  assign o_out   = sel ? ifb.layer_out_count : ifa.layer_out_count;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_err   = sel ? err_b  : err_a;
  assign o_nl    = sel ? nl_b   : nl_a;

  // Reference: walk the program list as the format describes it.
  task automatic build_model(input int plen);
    int inc;
    exp_q.delete();
    exp_err = 0; exp_n = 0; exp_last = 0;
    inc = int'(mem[0]);
    if (inc == 0) exp_err = 1;
    else begin
      for (int a = 1; a < plen; a++) begin
        exp_last = a;
        if (mem[a] == 8'd0) break;
        if (exp_n == MAX_LAYERS) begin exp_err = 1; break; end
        exp_q.push_back('{exp_n, inc, int'(mem[a])});
        inc = int'(mem[a]);
        exp_n++;
      end
    end
  endtask

  task automatic load_prog(input int w0, input int w1, input int w2, input int w3, input int w4);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 7);
    mem[0] = 8'(w0); mem[1] = 8'(w1); mem[2] = 8'(w2); mem[3] = 8'(w3); mem[4] = 8'(w4);
  endtask

  task automatic check_idle_zero(input string tag);
    vectors++;
    if ({o_en, o_valid, o_busy, o_done, o_err} !== 5'b0 || o_addr !== 8'd0 || o_idx !== 3'd0 ||
        o_in !== 8'd0 || o_out !== 8'd0 || o_nl !== 4'd0) begin
      miscompares++;
      $display("FAIL %s: en=%b valid=%b busy=%b done=%b err=%b addr=%0d idx=%0d in=%0d out=%0d nl=%0d, all required 0",
               tag, o_en, o_valid, o_busy, o_done, o_err, o_addr, o_idx, o_in, o_out, o_nl);
    end
  endtask

  task automatic run_prog(input string tag, input bit s, input int plen, input int stall,
                          input int ldly, input bit poke, input int rst_layer);
    int cyc, st, ldc, first_v, max_rd, acc;
    bit prev_v, poked, fin;
    desc_t snap, e;
    build_model(plen);
    cyc = 0; st = 0; ldc = -1; first_v = -1; max_rd = -1; acc = 0;
    prev_v = 0; poked = 0; fin = 0;
    snap = '{0, 0, 0};
    sel = s;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 500) begin
      ldone = 1'b0; start = 1'b0;
      if (rst_layer >= 0 && acc == rst_layer + 1 && ldc > 0) begin
        rst_n = 1'b0; ready = 1'b0;
        #1;
        check_idle_zero({tag, "_async_reset"});
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      vectors++;
      if (o_busy !== 1'b1) begin
        miscompares++; $display("FAIL %s_busy: got %b want 1 at cycle %0d", tag, o_busy, cyc);
      end
      if (o_en) begin
        if (int'(o_addr) > max_rd) max_rd = int'(o_addr);
        vectors++;
        if (int'(o_addr) >= plen) begin
          miscompares++; $display("FAIL %s_ram_window: read addr %0d, limit %0d", tag, o_addr, plen);
        end
      end
      if (poke && !poked && ldc > 0) begin start = 1'b1; poked = 1; end
      if (ldc > 0) begin
        ldc--;
        if (ldc == 0) begin ldone = 1'b1; ldc = -1; end
      end
      if (o_valid) begin
        if (first_v < 0) first_v = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s_extra_desc: got (%0d,%0d,%0d) want none", tag, o_idx, o_in, o_out);
        end else begin
          e = exp_q[0];
          if (o_idx !== 3'(e.idx) || o_in !== 8'(e.inc) || o_out !== 8'(e.outc)) begin
            miscompares++;
            $display("FAIL %s_desc: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tag, o_idx, o_in, o_out, e.idx, e.inc, e.outc);
          end
        end
        if (prev_v) begin
          vectors++;
          if (int'(o_idx) != snap.idx || int'(o_in) != snap.inc || int'(o_out) != snap.outc) begin
            miscompares++;
            $display("FAIL %s_stable: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tag, o_idx, o_in, o_out, snap.idx, snap.inc, snap.outc);
          end
        end
        snap = '{int'(o_idx), int'(o_in), int'(o_out)};
        prev_v = 1;
        if (st >= stall) begin
          ready = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          ldc = ldly; st = 0; acc++; prev_v = 0;
        end else begin
          ready = 1'b0; st++;
          if (st == 2) ldone = 1'b1;
        end
      end else begin
        prev_v = 0;
        ready = 1'($urandom_range(0, 1));
      end
      if (o_done) begin
        fin = 1;
        vectors++;
        if (exp_q.size() != 0 || o_err !== 1'(exp_err) || o_nl !== 4'(exp_n) || max_rd != exp_last) begin
          miscompares++;
          $display("FAIL %s_end: left=%0d err=%b nl=%0d maxrd=%0d want left=0 err=%0d nl=%0d maxrd=%0d",
                   tag, exp_q.size(), o_err, o_nl, max_rd, exp_err, exp_n, exp_last);
        end
        vectors++;
        if (first_v != ((exp_n > 0) ? 2 : -1)) begin
          miscompares++;
          $display("FAIL %s_latency: first valid at %0d want %0d", tag, first_v, (exp_n > 0) ? 2 : -1);
        end
        @(negedge clk);
        ready = 1'b0; ldone = 1'b0;
        vectors++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
          miscompares++; $display("FAIL %s_idle_after: done=%b busy=%b want 0/0", tag, o_done, o_busy);
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    ready = 1'b0;
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, cyc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_idle_zero("reset_a");
    sel = 1'b1; #1; check_idle_zero("reset_b");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load_prog(4, 3, 8, 5, 9);
    run_prog("basic", 1'b0, PLEN_A, 0, 2, 1'b0, -1);
  endtask

  task automatic test_error_header;
    load_prog(0, 3, 8, 5, 9);
    run_prog("zero_header", 1'b0, PLEN_A, 0, 2, 1'b0, -1);
    load_prog(6, 2, 7, 1, 9);
    run_prog("error_clear", 1'b0, PLEN_A, 0, 1, 1'b0, -1);
  endtask

  task automatic test_zero_layer;
    load_prog(4, 3, 0, 5, 9);
    run_prog("zero_layer", 1'b0, PLEN_A, 0, 2, 1'b0, -1);
  endtask

  task automatic test_backpressure;
    load_prog(4, 3, 8, 5, 9);
    run_prog("backpressure", 1'b0, PLEN_A, 5, 2, 1'b0, -1);
  endtask

  task automatic test_start_in_wait;
    load_prog(4, 3, 8, 5, 9);
    run_prog("start_in_wait", 1'b0, PLEN_A, 1, 3, 1'b1, -1);
  endtask

  task automatic test_reset_midrun;
    load_prog(4, 3, 8, 5, 9);
    run_prog("midrun", 1'b0, PLEN_A, 0, 2, 1'b0, 1);
    run_prog("after_reset", 1'b0, PLEN_A, 0, 2, 1'b0, -1);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    run_prog("overflow", 1'b1, PLEN_B, 0, 1, 1'b0, -1);
  endtask

  task automatic test_random;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) mem[0] = 8'd0;
      for (int i = 1; i < 16; i++) if ($urandom_range(0, 99) < 12) mem[i] = 8'd0;
      run_prog("random", 1'b1, PLEN_B, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_error_header;
    test_zero_layer;
    test_backpressure;
    test_start_in_wait;
    test_reset_midrun;
    test_overflow;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
